// File: rtl/gui_sequencer_if.sv
// Pixel-bus / control bundle between the screen sequencer and the pixel mux plus game logic.
// The pause line exists only when PAUSE_EN is defined.
interface gui_sequencer_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           start;
  logic           isDead;
`ifdef PAUSE_EN
  logic           pause;
`endif
  logic           plot;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     layer;
  logic           playing;
  logic           paused;

  // master: the sequencer, which owns the raster and layer outputs
  modport master (
    input  start,
    input  isDead,
`ifdef PAUSE_EN
    input  pause,
`endif
    output plot,
    output x,
    output y,
    output layer,
    output playing,
    output paused
  );

  modport slave (
    output start,
    output isDead,
`ifdef PAUSE_EN
    output pause,
`endif
    input  plot,
    input  x,
    input  y,
    input  layer,
    input  playing,
    input  paused
  );
endinterface

// File: rtl/gui_sequencer.sv
// Screen sequencer: title -> map -> play -> death flash -> game-over, driving a raster scan and layer code.
// Defining PAUSE_EN adds a pause input and the PAUSED/REDRAW states.
module gui_sequencer #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int FLASH_COUNT = 3,
  parameter int HOLD_CYCLES = 12_500_000,
  parameter int HOLD_W      = 24
) (
  input  logic            clk,
  input  logic            reset,
  gui_sequencer_if.master bus
);

  localparam int FLASH_W = (FLASH_COUNT > 0) ? $clog2(FLASH_COUNT + 1) : 1;

  typedef enum logic [3:0] {
    S_DRAW_TITLE = 4'd0,
    S_TITLE_WAIT,
    S_DRAW_MAP,
    S_PLAY,
    S_FLASH_RED,
    S_HOLD_RED,
    S_FLASH_MAP,
    S_HOLD_MAP,
    S_DRAW_GO,
    S_GAME_OVER
`ifdef PAUSE_EN
    ,
    S_PAUSED,
    S_REDRAW
`endif
  } state_e;

  typedef enum logic [2:0] {
    L_NONE  = 3'd0,
    L_TITLE = 3'd1,
    L_MAP   = 3'd2,
    L_RED   = 3'd3,
    L_GO    = 3'd4
  } layer_e;

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [FLASH_W-1:0]  flash_q, flash_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                start_q;

  logic   plot, playing, paused;
  layer_e layer;
  logic   start_edge, x_last, frame_last, hold_done;

  assign start_edge = bus.start & ~start_q;
  assign x_last     = (x_q == X_W'(SCREEN_W - 1));
  assign frame_last = x_last && (y_q == Y_W'(SCREEN_H - 1));
  assign hold_done  = (hold_q == HOLD_W'(HOLD_CYCLES - 1));

`ifdef PAUSE_EN
  logic pause_q, pause_edge;
  assign pause_edge = bus.pause & ~pause_q;
`endif

  always_comb begin
    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    state_d = state_q;
    x_d     = '0;
    y_d     = '0;
    flash_d = flash_q;
    hold_d  = '0;
    plot    = 1'b0;
    layer   = L_NONE;
    playing = 1'b0;
    paused  = 1'b0;
    case (state_q)
      S_DRAW_TITLE: begin
        plot  = 1'b1;
        layer = L_TITLE;
        if (frame_last) state_d = S_TITLE_WAIT;
      end
      S_TITLE_WAIT: if (start_edge) state_d = S_DRAW_MAP;
      S_DRAW_MAP: begin
        plot  = 1'b1;
        layer = L_MAP;
        if (frame_last) state_d = S_PLAY;
      end
      S_PLAY: begin
        playing = 1'b1;
        // death wins over a simultaneous pause edge
        if (bus.isDead) state_d = (FLASH_COUNT > 0) ? S_FLASH_RED : S_DRAW_GO;
`ifdef PAUSE_EN
        else if (pause_edge) state_d = S_PAUSED;
`endif
      end
      S_FLASH_RED: begin
        plot  = 1'b1;
        layer = L_RED;
        if (frame_last) state_d = S_HOLD_RED;
      end
      S_HOLD_RED: begin
        if (hold_done) state_d = S_FLASH_MAP;
        else           hold_d  = hold_q + 1'b1;
      end
      S_FLASH_MAP: begin
        plot  = 1'b1;
        layer = L_MAP;
        if (frame_last) begin
          state_d = S_HOLD_MAP;
          flash_d = flash_q + 1'b1;
        end
      end
      S_HOLD_MAP: begin
        if (hold_done) state_d = (flash_q == FLASH_W'(FLASH_COUNT)) ? S_DRAW_GO : S_FLASH_RED;
        else           hold_d  = hold_q + 1'b1;
      end
      S_DRAW_GO: begin
        plot  = 1'b1;
        layer = L_GO;
        if (frame_last) begin
          state_d = S_GAME_OVER;
          flash_d = '0;
        end
      end
      S_GAME_OVER: if (start_edge) state_d = S_DRAW_TITLE;
`ifdef PAUSE_EN
      S_PAUSED: begin
        paused = 1'b1;
        if (pause_edge) state_d = S_REDRAW;
      end
      S_REDRAW: begin
        plot  = 1'b1;
        layer = L_MAP;
        if (frame_last) state_d = S_PLAY;
      end
`endif
      default: begin
        state_d = S_DRAW_TITLE;
        flash_d = '0;
      end
    endcase
    // raster advances only while drawing; the last pixel leaves x,y at the 0 default
    if (plot && !frame_last) begin
      x_d = x_last ? '0 : x_q + 1'b1;
      y_d = x_last ? y_q + 1'b1 : y_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_DRAW_TITLE;
      x_q     <= '0;
      y_q     <= '0;
      flash_q <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
`ifdef PAUSE_EN
      pause_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      flash_q <= flash_d;
      hold_q  <= hold_d;
      start_q <= bus.start;
`ifdef PAUSE_EN
      pause_q <= bus.pause;
`endif
    end
  end

  assign bus.plot    = plot;
  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.layer   = layer;
  assign bus.playing = playing;
  assign bus.paused  = paused;

endmodule

// File: tb/tb_gui_sequencer.sv
// Self-checking bench for gui_sequencer: directed screen-flow steps plus random start/death/reset
// traffic, all compared each cycle against a frame/pixel-index reference model.
module tb_gui_sequencer;
  localparam int W = 4, H = 3, NP = W * H, FC = 2, HOLD = 5;
  localparam int XW = 2, YW = 2, HW = 4;

  logic clk = 1'b0;
  logic reset, reset0;
  always #5 clk = ~clk;

  gui_sequencer_if #(.X_W(XW), .Y_W(YW)) bus ();
  gui_sequencer_if #(.X_W(XW), .Y_W(YW)) bus0 ();

  gui_sequencer #(.SCREEN_W(W), .SCREEN_H(H), .X_W(XW), .Y_W(YW), .FLASH_COUNT(FC),
                  .HOLD_CYCLES(HOLD), .HOLD_W(HW))
    dut (.clk(clk), .reset(reset), .bus(bus));

  gui_sequencer #(.SCREEN_W(W), .SCREEN_H(H), .X_W(XW), .Y_W(YW), .FLASH_COUNT(0),
                  .HOLD_CYCLES(HOLD), .HOLD_W(HW))
    dut0 (.clk(clk), .reset(reset0), .bus(bus0));

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model: screen + pixel index ----------------
  typedef enum {M_TITLE, M_TWAIT, M_MAP, M_PLAY, M_RED, M_HRED, M_FMAP, M_HMAP,
                M_GO, M_GOVER, M_PAUSED, M_REDRAW} scr_e;
  scr_e m_scr;
  int   m_pix, m_hold, m_flash;
  bit   m_sprev, m_pprev;

  function automatic int scr_layer(scr_e s);
    case (s)
      M_TITLE:                 return 1;
      M_MAP, M_FMAP, M_REDRAW: return 2;
      M_RED:                   return 3;
      M_GO:                    return 4;
      default:                 return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_scr = M_TITLE; m_pix = 0; m_hold = 0; m_flash = 0; m_sprev = 0; m_pprev = 0;
  endtask

  task automatic model_step(input bit st, input bit dead, input bit pz);
    bit sedge, pedge;
    sedge = st && !m_sprev;
    pedge = pz && !m_pprev;
    m_sprev = st;
    m_pprev = pz;
    if (scr_layer(m_scr) != 0) begin
      if (m_pix < NP - 1) m_pix++;
      else begin
        m_pix = 0;
        case (m_scr)
          M_TITLE:          m_scr = M_TWAIT;
          M_MAP, M_REDRAW:  m_scr = M_PLAY;
          M_RED:  begin m_scr = M_HRED; m_hold = 0; end
          M_FMAP: begin m_scr = M_HMAP; m_hold = 0; m_flash++; end
          M_GO:   begin m_scr = M_GOVER; m_flash = 0; end
          default: ;
        endcase
      end
    end else begin
      case (m_scr)
        M_TWAIT:  if (sedge) m_scr = M_MAP;
        M_GOVER:  if (sedge) m_scr = M_TITLE;
        M_PLAY:   if (dead) m_scr = (FC > 0) ? M_RED : M_GO;
                  else if (pedge) m_scr = M_PAUSED;
        M_PAUSED: if (pedge) m_scr = M_REDRAW;
        M_HRED: begin m_hold++; if (m_hold == HOLD) m_scr = M_FMAP; end
        M_HMAP: begin m_hold++; if (m_hold == HOLD) m_scr = (m_flash == FC) ? M_GO : M_RED; end
        default: ;
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int lay;
    bit pl;
    lay = scr_layer(m_scr);
    pl  = (lay != 0);
    check("plot",    32'(bus.plot),    32'(pl));
    check("layer",   32'(bus.layer),   32'(lay));
    check("x",       32'(bus.x),       pl ? 32'(m_pix % W) : 32'd0);
    check("y",       32'(bus.y),       pl ? 32'(m_pix / W) : 32'd0);
    check("playing", 32'(bus.playing), 32'(m_scr == M_PLAY));
    check("paused",  32'(bus.paused),  32'(m_scr == M_PAUSED));
  endtask

  task automatic cycle();
    bit st, dead, pz;
    st = bus.start; dead = bus.isDead; pz = 1'b0;
`ifdef PAUSE_EN
    pz = bus.pause;
`endif
    @(posedge clk);
    #1;
    if (!reset) model_step(st, dead, pz);
    compare_all();
  endtask

  task automatic wait_playing(input string tag);
    int k = 0;
    while (!bus.playing && k < 200) begin
      bus.start = ~bus.start;
      cycle();
      k++;
    end
    bus.start = 1'b0;
    check(tag, 32'(bus.playing), 32'd1);
  endtask

  task automatic death_to_gameover(input string tag);
    int n = 0, n_red = 0;
    bit seen_go = 0;
    bus.isDead = 1'b1;
    cycle();
    bus.isDead = 1'b0;
    while (n < 200) begin
      if (bus.layer == 3'd4) seen_go = 1;
      if (bus.layer == 3'd3) n_red++;
      if (seen_go && !bus.plot) break;
      cycle();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd80);
    check({tag, "_red_cycles"}, 32'(n_red), 32'(FC * NP));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k, n3, n4;
    bit found;
    bus.start = 0; bus.isDead = 0;
    bus0.start = 0; bus0.isDead = 0;
`ifdef PAUSE_EN
    bus.pause = 0; bus0.pause = 0;
`endif
    reset = 1'b1; reset0 = 1'b1;
    model_reset();

    // reset state: DRAW_TITLE decode at pixel (0,0)
    repeat (2) @(posedge clk);
    #1;
    check("rst_plot", 32'(bus.plot), 32'd1);
    check("rst_layer", 32'(bus.layer), 32'd1);
    check("rst_xy", {30'd0, bus.x, bus.y}, 32'd0);
    reset = 1'b0;
    compare_all();

    // title frame: exactly NP plot cycles, then TITLE_WAIT
    n = 0;
    while (bus.plot && n < 100) begin n++; cycle(); end
    check("title_len", 32'(n), 32'(NP));

    // start held high: one map frame, then PLAY; held level causes nothing more
    bus.start = 1'b1;
    n = 0; k = 0;
    while (!bus.playing && k < 100) begin
      if (bus.layer == 3'd2) n++;
      cycle(); k++;
    end
    check("map_len", 32'(n), 32'(NP));
    check("playing_after_map", 32'(bus.playing), 32'd1);
    repeat (20) cycle();
    check("stay_play", 32'(bus.playing), 32'd1);

    // death with two flash pairs, then game-over 80 cycles later
    death_to_gameover("death1");
    repeat (5) cycle();
    check("gover_holds", 32'(bus.plot), 32'd0);
    bus.start = 1'b0; cycle();
    bus.start = 1'b1; cycle();
    check("restart_title", 32'(bus.layer), 32'd1);
    bus.start = 1'b0;

    // reset in the middle of a red flash at pixel (2,1)
    wait_playing("play2");
    bus.isDead = 1'b1; cycle(); bus.isDead = 1'b0;
    found = 0; k = 0;
    while (!found && k < 60) begin
      if (bus.layer == 3'd3 && bus.x == 2'd2 && bus.y == 2'd1) found = 1;
      else begin cycle(); k++; end
    end
    check("found_red_2_1", 32'(found), 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_layer", 32'(bus.layer), 32'd1);
    check("async_rst_xy", {30'd0, bus.x, bus.y}, 32'd0);
    cycle();
    reset = 1'b0;
    wait_playing("play3");
    death_to_gameover("death2");

`ifdef PAUSE_EN
    bus.start = 1'b0; cycle(); bus.start = 1'b1; cycle(); bus.start = 1'b0;
    wait_playing("play_p");
    bus.pause = 1'b1; cycle();
    check("pause_paused", 32'(bus.paused), 32'd1);
    check("pause_playing", 32'(bus.playing), 32'd0);
    bus.pause = 1'b0; cycle();
    bus.pause = 1'b1;
    n = 0; k = 0;
    while (!bus.playing && k < 100) begin
      if (bus.layer == 3'd2) n++;
      cycle(); k++;
    end
    check("redraw_len", 32'(n), 32'(NP));
    bus.pause = 1'b0; cycle();
    bus.pause = 1'b1; bus.isDead = 1'b1; cycle();
    bus.pause = 1'b0; bus.isDead = 1'b0;
    check("dead_beats_pause", 32'(bus.layer), 32'd3);
`endif

    // random traffic against the model, with rare async resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) bus.start = ~bus.start;
      bus.isDead = ($urandom_range(0, 15) == 0);
`ifdef PAUSE_EN
      if ($urandom_range(0, 9) == 0) bus.pause = ~bus.pause;
`endif
      reset = ($urandom_range(0, 399) == 0);
      if (reset) model_reset();
      cycle();
    end
    reset = 1'b0;

    // FLASH_COUNT=0 instance: death goes straight to game-over, no red layer
    reset0 = 1'b0;
    k = 0;
    while (!bus0.playing && k < 200) begin
      bus0.start = ~bus0.start;
      cycle(); k++;
    end
    check("fc0_playing", 32'(bus0.playing), 32'd1);
    bus0.isDead = 1'b1; cycle(); bus0.isDead = 1'b0;
    check("fc0_go_first", 32'(bus0.layer), 32'd4);
    n3 = 0; n4 = 0;
    for (int i = 0; i < NP; i++) begin
      if (bus0.layer == 3'd3) n3++;
      if (bus0.layer == 3'd4) n4++;
      cycle();
    end
    check("fc0_no_red", 32'(n3), 32'd0);
    check("fc0_go_len", 32'(n4), 32'(NP));
    check("fc0_gover", {28'd0, bus0.plot, bus0.layer}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
